// File: rtl/mdu_alu_sequencer_if.sv
// Bundle of the pipeline, shared-ALU and result signals of the multiply/divide sequencer.
// The master drives requests, the pipeline operands and the ALU result; the slave is the sequencer.
interface mdu_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] cpu_A;
  logic [WIDTH-1:0] cpu_B;
  logic [1:0]       cpu_ALUOp;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [1:0]       alu_ALUOp;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cpu_A, cpu_B, cpu_ALUOp, alu_result,
    input  alu_A, alu_B, alu_ALUOp, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cpu_A, cpu_B, cpu_ALUOp, alu_result,
    output alu_A, alu_B, alu_ALUOp, busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_alu_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU unit that borrows the pipeline's ALU for its add/subtract.
// One iteration per cycle; hi/lo are written only when an operation completes.
//
// state  | meaning
// S_IDLE | ALU passed through from pipeline, waiting for start
// S_MUL  | shift-add multiply iteration, ALU doing ADD
// S_DIV  | restoring divide iteration, ALU doing SUB
// S_DONE | result valid, done pulse, ALU passed through
module mdu_alu_sequencer #(
  parameter int WIDTH     = 32,
  parameter bit FAST_ZERO = 1'b1
) (
  input logic                clk,
  input logic                reset,
  mdu_alu_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_fast;
  logic             w_last;
  logic             w_mul_c;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_r33;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_fast = FAST_ZERO && (bus.op ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0)));
  assign w_last = (r_count == LAST);

  // Multiply step: carry out of P_hi + a is recovered from the wrapped sum.
  always_comb begin
    w_mul_c = (bus.alu_result < r_acc_hi);
    if (r_acc_lo[0]) begin
      {w_mul_hi, w_mul_lo} = {w_mul_c, bus.alu_result, r_acc_lo[WIDTH-1:1]};
    end else begin
      {w_mul_hi, w_mul_lo} = {1'b0, r_acc_hi, r_acc_lo[WIDTH-1:1]};
    end
  end

  // Divide step: when r33[32] is set the wrapped difference is already the remainder.
  always_comb begin
    w_r33    = {r_acc_hi, r_acc_lo[WIDTH-1]};
    w_ge     = w_r33[WIDTH] | (w_r33[WIDTH-1:0] >= r_opnd);
    w_div_hi = w_ge ? bus.alu_result : w_r33[WIDTH-1:0];
    w_div_lo = {r_acc_lo[WIDTH-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_next = w_fast ? S_DONE : (bus.op ? S_DIV : S_MUL);
      S_MUL:  if (w_last) w_next = S_DONE;
      S_DIV:  if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count  <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_count  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= bus.op ? bus.a : bus.b;
            r_opnd   <= bus.op ? bus.b : bus.a;
            if (w_fast) begin
              r_hi <= bus.op ? bus.a : '0;
              r_lo <= bus.op ? '1 : '0;
            end
          end
        end
        S_MUL: begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_hi <= w_mul_hi;
            r_lo <= w_mul_lo;
          end
        end
        S_DIV: begin
          r_acc_hi <= w_div_hi;
          r_acc_lo <= w_div_lo;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_DONE);
    bus.hi        = r_hi;
    bus.lo        = r_lo;
    bus.alu_A     = bus.cpu_A;
    bus.alu_B     = bus.cpu_B;
    bus.alu_ALUOp = bus.cpu_ALUOp;
    case (r_state)
      S_MUL: begin
        bus.alu_A     = r_acc_hi;
        bus.alu_B     = r_opnd;
        bus.alu_ALUOp = 2'b00;
      end
      S_DIV: begin
        bus.alu_A     = w_r33[WIDTH-1:0];
        bus.alu_B     = r_opnd;
        bus.alu_ALUOp = 2'b01;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mdu_alu_sequencer.sv
// Bench for mdu_alu_sequencer: a FAST_ZERO=1 and a FAST_ZERO=0 instance share stimulus,
// each with its own ALU model; results are compared with plain arithmetic.
module tb_mdu_alu_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] cpu_A = 32'd5;
  logic [31:0] cpu_B = 32'd3;
  logic [1:0]  cpu_ALUOp = 2'b01;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mdu_alu_sequencer_if #(.WIDTH(32)) bus_f ();
  mdu_alu_sequencer_if #(.WIDTH(32)) bus_s ();

  function automatic logic [31:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [1:0] f);
    case (f)
      2'b00:   return x + y;
      2'b01:   return x - y;
      2'b10:   return x | y;
      default: return 32'd0;
    endcase
  endfunction

  assign bus_f.start = start;      assign bus_s.start = start;
  assign bus_f.op = op;            assign bus_s.op = op;
  assign bus_f.a = a;              assign bus_s.a = a;
  assign bus_f.b = b;              assign bus_s.b = b;
  assign bus_f.cpu_A = cpu_A;      assign bus_s.cpu_A = cpu_A;
  assign bus_f.cpu_B = cpu_B;      assign bus_s.cpu_B = cpu_B;
  assign bus_f.cpu_ALUOp = cpu_ALUOp;
  assign bus_s.cpu_ALUOp = cpu_ALUOp;
  assign bus_f.alu_result = alu_model(bus_f.alu_A, bus_f.alu_B, bus_f.alu_ALUOp);
  assign bus_s.alu_result = alu_model(bus_s.alu_A, bus_s.alu_B, bus_s.alu_ALUOp);

  mdu_alu_sequencer #(.WIDTH(32), .FAST_ZERO(1'b1)) dut_f (.clk(clk), .reset(reset), .bus(bus_f));
  mdu_alu_sequencer #(.WIDTH(32), .FAST_ZERO(1'b0)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_result(input logic o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    if (!o) begin
      p = {32'd0, x} * {32'd0, y};
      return p;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    return {x % y, x / y};
  endfunction

  function automatic bit is_zero_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    return o ? (y == 32'd0) : (x == 32'd0 || y == 32'd0);
  endfunction

  // Runs one operation on both instances and checks timing, ALU ownership and results.
  task automatic do_op(input string name, input logic o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [63:0] exp);
    int lat_f, first_f, first_s, cnt_f, cnt_s, bad_busy, bad_alu;
    logic [63:0] res_f, res_s;
    lat_f = is_zero_op(o, av, bv) ? 1 : 33;
    first_f = -1; first_s = -1; cnt_f = 0; cnt_s = 0; bad_busy = 0; bad_alu = 0;
    res_f = '0; res_s = '0;
    op = o; a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      if (bus_f.done) begin cnt_f++; if (first_f < 0) first_f = k; res_f = {bus_f.hi, bus_f.lo}; end
      if (bus_s.done) begin cnt_s++; if (first_s < 0) first_s = k; res_s = {bus_s.hi, bus_s.lo}; end
      if (bus_f.busy !== (k <= lat_f)) bad_busy++;
      if (bus_s.busy !== (k <= 33)) bad_busy++;
      if (k < 33 && bus_s.alu_ALUOp !== (o ? 2'b01 : 2'b00)) bad_alu++;
      if (k < lat_f && bus_f.alu_ALUOp !== (o ? 2'b01 : 2'b00)) bad_alu++;
      if (lat_f == 1 && {bus_f.alu_A, bus_f.alu_B, bus_f.alu_ALUOp} !== {cpu_A, cpu_B, cpu_ALUOp})
        bad_alu++;
      step();
    end
    chk({name, " done_cycle_fast"}, 64'(first_f), 64'(lat_f));
    chk({name, " done_cycle_slow"}, 64'(first_s), 64'd33);
    chk({name, " done_count"}, {32'(cnt_f), 32'(cnt_s)}, {32'd1, 32'd1});
    chk({name, " result_fast"}, res_f, exp);
    chk({name, " result_slow"}, res_s, exp);
    chk({name, " busy_window"}, 64'(bad_busy), 64'd0);
    chk({name, " alu_owner"}, 64'(bad_alu), 64'd0);
    chk({name, " hold"}, {bus_s.hi, bus_s.lo}, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_done, first, second;
    logic [63:0] r1, r2;
    logic [31:0] ra, rb;
    logic        ro;

    vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{1'b1, 32'd100, 32'd7, 32'd2, 32'd14});
    vecs.push_back('{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1});
    vecs.push_back('{1'b1, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 32'd3, 32'd4, 32'd0, 32'd12});
    vecs.push_back('{1'b0, 32'd0, 32'd5, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 32'h8000_0000, 32'd2, 32'd1, 32'd0});
    vecs.push_back('{1'b1, 32'd5, 32'd9, 32'd5, 32'd0});
    vecs.push_back('{1'b1, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'hDEAD_BEEF});

    // Reset held two cycles
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("reset busy_done", {62'd0, bus_f.busy, bus_f.done}, 64'd0);
    chk("reset hi_lo", {bus_f.hi, bus_f.lo}, 64'd0);
    chk("reset passthru", {30'd0, bus_s.alu_A[15:0], bus_s.alu_B[15:0], bus_s.alu_ALUOp},
        {30'd0, 16'd5, 16'd3, 2'b01});
    step();
    chk("idle passthru", {bus_f.alu_A, bus_f.alu_B}, {32'd5, 32'd3});

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
    end

    // Start during a running MULTU is ignored; a start right after done is accepted.
    n_done = 0; first = -1; second = -1; r1 = '0; r2 = '0;
    op = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (k == 5)  begin op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1; end
      if (k == 6)  start = 1'b0;
      if (k == 34) begin
        chk("b2b idle_at_34", 64'(bus_s.busy), 64'd0);
        op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
      end
      if (k == 35) begin
        start = 1'b0;
        chk("b2b busy_at_35", 64'(bus_s.busy), 64'd1);
      end
      if (bus_s.done) begin
        n_done++;
        if (first < 0) begin first = k; r1 = {bus_s.hi, bus_s.lo}; end
        else begin second = k; r2 = {bus_s.hi, bus_s.lo}; end
      end
      step();
    end
    chk("b2b done_count", 64'(n_done), 64'd2);
    chk("b2b first_done", {32'(first), 32'(second)}, {32'd33, 32'd67});
    chk("b2b mul_result", r1, {32'd0, 32'd12});
    chk("b2b div_result", r2, {32'd2, 32'd14});

    // Reset in the middle of a divide aborts it.
    n_done = 0;
    op = 1'b1; a = 32'd1000; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 10) reset = 1'b1;
      if (k == 11) begin
        chk("abort busy", {62'd0, bus_s.busy, bus_f.busy}, 64'd0);
        chk("abort hi_lo", {bus_s.hi, bus_s.lo}, 64'd0);
        chk("abort passthru", {bus_s.alu_A, bus_s.alu_B}, {cpu_A, cpu_B});
        chk("abort aluop", 64'(bus_s.alu_ALUOp), 64'(cpu_ALUOp));
        reset = 1'b0;
      end
      if (bus_s.done || bus_f.done) n_done++;
      step();
    end
    chk("abort no_done", 64'(n_done), 64'd0);

    // Random operations against the arithmetic reference
    for (int i = 0; i < 20; i++) begin
      ro = 1'(($urandom & 32'd1));
      ra = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      cpu_A = $urandom; cpu_B = $urandom; cpu_ALUOp = 2'($urandom_range(0, 2));
      do_op($sformatf("rnd%0d", i), ro, ra, rb, ref_result(ro, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
